// File: rtl/mod5_link_pkg.sv
// Shared definitions for both ends of the 8-bit serial link in the mod-5 datapath.
package mod5_link_pkg;

  localparam int unsigned LINK_WORD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/word_hold_reg.sv
// Output hold register: presents a completed word on a valid/ready port and
// pulses drop_o when a new word arrives while the held one is still unaccepted.
module word_hold_reg
  import mod5_link_pkg::*;
#(
  parameter int unsigned WIDTH = LINK_WORD_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // A load is accepted when the slot is empty or is being emptied at this edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i && (!valid_q || ready_i)) begin
      data_q  <= word_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign drop_o  = load_i && valid_q && !ready_i;

endmodule

// File: rtl/register_8_serial_in.sv
// Serial-in, parallel-out receiver: rebuilds MSB-first words from the link
// bit stream, with sticky overrun and framing-error flags.
module register_8_serial_in
  import mod5_link_pkg::*;
#(
  parameter int unsigned WIDTH      = LINK_WORD_W,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             serial_in,
  input  logic             frame_start,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, frame_err_q;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             ferr_set;
  logic             drop;

  assign word = {shift_q[WIDTH-2:0], serial_in};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    ferr_set = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            shift_d = word;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shift_d = word;
          // bit_cnt==0 only occurs in CONTINUOUS mode, where frame_start is a legal MSB marker
          if (frame_start && (cnt_q != '0)) begin
            ferr_set = 1'b1;
            cnt_d    = CNT_W'(1);
          end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            if (!CONTINUOUS) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      if (drop)             overrun_q <= 1'b1;
      else if (clear_flags) overrun_q <= 1'b0;
      if (ferr_set)         frame_err_q <= 1'b1;
      else if (clear_flags) frame_err_q <= 1'b0;
    end
  end

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock  (clock),
    .reset_n(reset_n),
    .load_i (complete),
    .word_i (word),
    .ready_i(out_ready),
    .data_o (parallel_out),
    .valid_o(out_valid),
    .drop_o (drop)
  );

  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_register_8_serial_in.sv
// Directed bench for register_8_serial_in: one framed instance and one CONTINUOUS instance on shared stimulus.
module tb_register_8_serial_in;

  logic       clk = 1'b0;
  logic       reset_n, en, serial_in, frame_start, clear_flags, out_ready;
  logic [7:0] po0, po1;
  logic       ov0, ov1, bz0, bz1, of0, of1, fe0, fe1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  register_8_serial_in #(.WIDTH(8), .CONTINUOUS(1'b0)) dut0 (
    .clock(clk), .reset_n(reset_n), .en(en), .serial_in(serial_in),
    .frame_start(frame_start), .clear_flags(clear_flags), .parallel_out(po0),
    .out_valid(ov0), .out_ready(out_ready), .busy(bz0), .overrun(of0), .frame_err(fe0)
  );

  register_8_serial_in #(.WIDTH(8), .CONTINUOUS(1'b1)) dut1 (
    .clock(clk), .reset_n(reset_n), .en(en), .serial_in(serial_in),
    .frame_start(frame_start), .clear_flags(clear_flags), .parallel_out(po1),
    .out_valid(ov1), .out_ready(out_ready), .busy(bz1), .overrun(of1), .frame_err(fe1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic fs, input logic b);
    en = 1'b1; frame_start = fs; serial_in = b;
    tick();
    en = 1'b0; frame_start = 1'b0;
  endtask

  // gap idle cycles before each bit carry junk on serial_in/frame_start with en low
  task automatic send_word(input logic [7:0] w, input int gap, input logic fs_first);
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        en = 1'b0; frame_start = 1'b1; serial_in = ~serial_in;
        tick();
      end
      send_bit((i == 7) ? fs_first : 1'b0, w[i]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; frame_start = 1'b0; clear_flags = 1'b0; out_ready = 1'b0;
    serial_in = 1'b0;
    for (int i = 0; i < 4; i++) begin serial_in = ~serial_in; tick(); end
    checks++;
    if ({po0, ov0, bz0, of0, fe0} !== 12'h000) begin
      failures++; $display("FAIL reset_outputs got=%h exp=000", {po0, ov0, bz0, of0, fe0});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin serial_in = ~serial_in; tick(); end
    en = 1'b0;
    checks++;
    if (bz0 !== 1'b0 || ov0 !== 1'b0) begin
      failures++; $display("FAIL reset_idle got busy=%b valid=%b exp busy=0 valid=0", bz0, ov0);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_word(8'hA5, 0, 1'b1);
    checks++;
    if (ov0 !== 1'b1 || po0 !== 8'hA5 || of0 !== 1'b0) begin
      failures++; $display("FAIL basic_word got v=%b d=%h ov=%b exp v=1 d=a5 ov=0", ov0, po0, of0);
    end
    checks++;
    if (bz0 !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", bz0); end
    tick();
    checks++;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", ov0); end
  endtask

  task automatic test_gated_en();
    out_ready = 1'b1;
    send_word(8'h3C, 2, 1'b1);
    checks++;
    if (ov0 !== 1'b1 || po0 !== 8'h3C) begin
      failures++; $display("FAIL gated_word got v=%b d=%h exp v=1 d=3c", ov0, po0);
    end
    tick();
    checks++;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL gated_valid_drop got=%b exp=0", ov0); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_word(8'h11, 0, 1'b1);
    checks++;
    if (ov0 !== 1'b1 || po0 !== 8'h11 || of0 !== 1'b0) begin
      failures++; $display("FAIL ovr_first got v=%b d=%h ov=%b exp v=1 d=11 ov=0", ov0, po0, of0);
    end
    send_word(8'h22, 0, 1'b1);
    checks++;
    if (ov0 !== 1'b1 || po0 !== 8'h11 || of0 !== 1'b1) begin
      failures++; $display("FAIL ovr_second got v=%b d=%h ov=%b exp v=1 d=11 ov=1", ov0, po0, of0);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ov0 !== 1'b0 || po0 !== 8'h11) begin
      failures++; $display("FAIL ovr_transfer got v=%b d=%h exp v=0 d=11", ov0, po0);
    end
    tick();
    checks++;
    if (ov0 !== 1'b0 || of0 !== 1'b1) begin
      failures++; $display("FAIL ovr_single got v=%b ov=%b exp v=0 ov=1", ov0, of0);
    end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (of0 !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", of0); end
  endtask

  task automatic test_frame_err();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    checks++;
    if (bz0 !== 1'b1 || fe0 !== 1'b0) begin
      failures++; $display("FAIL ferr_partial got busy=%b fe=%b exp busy=1 fe=0", bz0, fe0);
    end
    send_word(8'h5A, 0, 1'b1);
    checks++;
    if (fe0 !== 1'b1 || ov0 !== 1'b1 || po0 !== 8'h5A || of0 !== 1'b0) begin
      failures++;
      $display("FAIL ferr_word got fe=%b v=%b d=%h ov=%b exp fe=1 v=1 d=5a ov=0", fe0, ov0, po0, of0);
    end
    tick();
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (fe0 !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", fe0); end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    clear_flags = 1'b1;
    send_bit(1'b1, 1'b0);
    clear_flags = 1'b0;
    checks++;
    if (fe0 !== 1'b1) begin failures++; $display("FAIL ferr_set_wins got=%b exp=1", fe0); end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (fe0 !== 1'b0) begin failures++; $display("FAIL ferr_clear2 got=%b exp=0", fe0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w2;
    w2 = 8'h81;
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (ov1 !== 1'b0 || bz1 !== 1'b0) begin
      failures++; $display("FAIL b2b_reset got v=%b busy=%b exp v=0 busy=0", ov1, bz1);
    end
    send_word(8'hC3, 0, 1'b1);
    checks++;
    if (ov1 !== 1'b1 || po1 !== 8'hC3 || bz1 !== 1'b1) begin
      failures++; $display("FAIL b2b_first got v=%b d=%h busy=%b exp v=1 d=c3 busy=1", ov1, po1, bz1);
    end
    out_ready = 1'b0;
    for (int i = 7; i >= 1; i--) send_bit(1'b0, w2[i]);
    checks++;
    if (ov1 !== 1'b1 || po1 !== 8'hC3) begin
      failures++; $display("FAIL b2b_hold got v=%b d=%h exp v=1 d=c3", ov1, po1);
    end
    out_ready = 1'b1;
    send_bit(1'b0, w2[0]);
    checks++;
    if (ov1 !== 1'b1 || po1 !== 8'h81 || of1 !== 1'b0 || fe1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got v=%b d=%h ov=%b fe=%b exp v=1 d=81 ov=0 fe=0", ov1, po1, of1, fe1);
    end
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    checks++;
    if (ov1 !== 1'b0 || bz1 !== 1'b1) begin
      failures++; $display("FAIL b2b_third_partial got v=%b busy=%b exp v=0 busy=1", ov1, bz1);
    end
    reset_n = 1'b0;
    send_bit(1'b0, 1'b1);
    reset_n = 1'b1;
    checks++;
    if (ov1 !== 1'b0 || bz1 !== 1'b0 || po1 !== 8'h00) begin
      failures++; $display("FAIL b2b_reset_mid got v=%b busy=%b d=%h exp v=0 busy=0 d=00", ov1, bz1, po1);
    end
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    tick();
    checks++;
    if (ov1 !== 1'b0 || bz1 !== 1'b0) begin
      failures++; $display("FAIL b2b_no_partial got v=%b busy=%b exp v=0 busy=0", ov1, bz1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gated_en();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
